hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised pipeline hazard unit for the ARM core.
- Keeps an internal tag pipeline (valid, dest, wb_en, mem_r_en) that mirrors the EXE..WB datapath stages, so the ID stage no longer needs to route exe_dest/mem_dest back.
- Raises `hazard` when an ID-stage source register has a pending write that cannot be forwarded; supports memory freeze, branch flush and a saturating stall counter.

Parameters:
REG_ADDR_W, 4, register-file address width
DEPTH, 2, number of tracked stages after ID (1=EXE, 2=MEM, ... DEPTH); must be >= 1
FWD_EXE_ALU, 0, 1 = ALU results in EXE are forwardable (only a load in EXE blocks); 0 = any EXE match blocks when forwarding is on
CNT_W, 16, stall counter width

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
forwarding_enable  input  1  forwarding unit active
freeze  input  1  pipeline frozen (memory not ready); tags hold
flush  input  1  branch taken; ID instruction is squashed
id_valid  input  1  ID stage holds a real instruction
id_r_n  input  REG_ADDR_W  source 1
id_r_d  input  REG_ADDR_W  source 2
id_two_src  input  1  source 2 is used
id_wb_en  input  1  ID instruction writes a register
id_mem_r_en  input  1  ID instruction is a load
id_dest  input  REG_ADDR_W  ID destination register
hazard  output  1  stall ID/IF, insert bubble into EXE
hazard_stage  output  DEPTH  one-hot-or-zero: lowest stage index causing the hazard
stall_count  output  CNT_W  number of cycles stalled by hazards

Behaviour:
- Tag[k], k=1..DEPTH, each = {v, dest, wb, ld}. Reset: all v=0, wb=0, ld=0, dest=0; stall_count=0.
- Per-stage match: match_k(r) = v_k & wb_k & (dest_k == r) & blk_k.
- Blocking with forwarding_enable=0: blk_k = 1 for all k.
- Blocking with forwarding_enable=1: blk_1 = FWD_EXE_ALU ? ld_1 : 1; blk_k = 0 for k>=2.
- hazard = id_valid & ~flush & (OR_k match_k(id_r_n) | (id_two_src & OR_k match_k(id_r_d))).
  - Purely combinational from current tags and ID inputs; zero-cycle latency.
  - hazard is 0 during reset because tags are cleared.
- hazard_stage: bit k-1 set for the smallest k whose match caused the hazard; 0 when hazard=0.
- Clocked update, priority rst > freeze > normal:
  - rst: clear as above.
  - freeze: all tags and stall_count hold. hazard still evaluates combinationally.
  - Normal: Tag[1] <= (id_valid & ~flush & ~hazard) ? {1, id_dest, id_wb_en, id_mem_r_en} : bubble (v=0, wb=0, ld=0). Tag[k] <= Tag[k-1] for k>=2. Tag[DEPTH] content drops out (written back).
- stall_count increments by 1 on a clock edge with hazard=1 & ~freeze & ~rst; saturates at all-ones.
- Register r0 is not special; all 2^REG_ADDR_W addresses compare.
- Two pending writes to the same register in different stages: both match; the lowest stage is reported.
- flush and hazard together: flush wins. hazard=0 and a bubble is inserted.
- A stall ends on its own: bubbles advance the blocking tag out of the blocking window.

Test Plan:
- Reset: assert rst 2 cycles with arbitrary inputs -> hazard=0, hazard_stage=0, stall_count=0; after release, id_r_n=3 with no prior issue -> hazard=0.
- No forwarding, DEPTH=2:
  - Issue dest=5, wb=1; next cycle ID r_n=5 -> hazard=1, hazard_stage=01 for 1 cycle, then hazard=1, hazard_stage=10 for 1 cycle, then 0.
  - stall_count goes 0->2 over those two cycles.
- Forwarding on, FWD_EXE_ALU=1:
  - ALU op dest=7, then ID r_d=7, two_src=1 -> hazard=0.
  - Load dest=7, then ID r_n=7 -> hazard=1 for exactly 1 cycle; the consumer issues the following cycle.
  - two_src=0 with r_d=7 -> hazard=0.
- Freeze: create hazard on dest=2 in EXE, hold freeze=1 for 3 cycles -> hazard stays 1, stall_count unchanged, tags unchanged; release -> normal drain.
- Flush: ID r_n matches EXE dest with flush=1 -> hazard=0 and Tag[1] becomes a bubble (next-cycle match on id_dest impossible).
- Saturation/param: CNT_W=2, force 5 stall cycles -> stall_count=3. DEPTH=4, forwarding off -> a single write blocks a consumer for 4 cycles, hazard_stage walks 0001 -> 1000.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destination tags for EXE..WB and
// stalls ID when a source register has a pending write that cannot be forwarded.
module hazard_scoreboard #(
   parameter int REG_ADDR_W  = 4,
   parameter int DEPTH       = 2,
   parameter bit FWD_EXE_ALU = 1'b0,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  forwarding_enable,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_r_n,
   input  logic [REG_ADDR_W-1:0] id_r_d,
   input  logic                  id_two_src,
   input  logic                  id_wb_en,
   input  logic                  id_mem_r_en,
   input  logic [REG_ADDR_W-1:0] id_dest,
   output logic                  hazard,
   output logic [DEPTH-1:0]      hazard_stage,
   output logic [CNT_W-1:0]      stall_count
);

   logic [DEPTH-1:0]      validQ, validD;
   logic [DEPTH-1:0]      wbQ, wbD;
   logic [DEPTH-1:0]      ldQ, ldD;
   logic [REG_ADDR_W-1:0] destQ [DEPTH];
   logic [REG_ADDR_W-1:0] destD [DEPTH];
   logic [CNT_W-1:0]      stallCntQ, stallCntD;

   logic [DEPTH-1:0]      blocking;
   logic [DEPTH-1:0]      matchAny;
   logic [DEPTH-1:0]      firstMatch;
   logic                  hazardInt;
   logic                  issue;

   // With forwarding on, only EXE can block (and only loads when ALU results forward).
   always_comb begin
      blocking = '0;
      matchAny = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (!forwarding_enable) begin
            blocking[k] = 1'b1;
         end else if (k == 0) begin
            blocking[k] = FWD_EXE_ALU ? ldQ[0] : 1'b1;
         end
         matchAny[k] = validQ[k] & wbQ[k] & blocking[k] &
                       ((destQ[k] == id_r_n) | (id_two_src & (destQ[k] == id_r_d)));
      end
   end

   always_comb begin
      firstMatch = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (matchAny[k]) begin
            firstMatch    = '0;
            firstMatch[k] = 1'b1;
         end
      end
   end

   assign hazardInt    = id_valid & ~flush & (|matchAny);
   assign hazard       = hazardInt;
   assign hazard_stage = hazardInt ? firstMatch : '0;
   assign stall_count  = stallCntQ;

   // A stalled or flushed ID slot enters EXE as a bubble.
   assign issue = id_valid & ~flush & ~hazardInt;

   always_comb begin
      validD[0] = issue;
      wbD[0]    = issue & id_wb_en;
      ldD[0]    = issue & id_mem_r_en;
      destD[0]  = issue ? id_dest : '0;
      for (int k = 1; k < DEPTH; k++) begin
         validD[k] = validQ[k-1];
         wbD[k]    = wbQ[k-1];
         ldD[k]    = ldQ[k-1];
         destD[k]  = destQ[k-1];
      end
      stallCntD = stallCntQ;
      if (hazardInt && (stallCntQ != '1)) begin
         stallCntD = stallCntQ + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         validQ    <= '0;
         wbQ       <= '0;
         ldQ       <= '0;
         stallCntQ <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            destQ[k] <= '0;
         end
      end else if (!freeze) begin
         validQ    <= validD;
         wbQ       <= wbD;
         ldQ       <= ldD;
         stallCntQ <= stallCntD;
         for (int k = 0; k < DEPTH; k++) begin
            destQ[k] <= destD[k];
         end
      end
   end

endmodule
